// File: rtl/count_direction_decoder.sv
// rtl/count_direction_decoder.sv - recovers and validates up/down direction from a sampled count stream
module count_direction_decoder #(
  parameter int WIDTH  = 3,
  parameter int LOCK_N = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] num_in,
  input  logic             valid_in,
  output logic             dir_out,
  output logic             locked,
  output logic             rev,
  output logic             step_err,
  output logic [7:0]       err_count,
  output logic [WIDTH-1:0] last_num
);

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_TRACK  = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_RUN = 4'(LOCK_N);
  localparam logic [WIDTH-1:0] DELTA_UP = WIDTH'(1);
  localparam logic [WIDTH-1:0] DELTA_DN = '1;

  state_t           state_q, state_d;
  logic             cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  logic             dir_q, dir_d;
  logic             locked_q, locked_d;
  logic             rev_q, rev_d;
  logic             step_err_q, step_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [WIDTH-1:0] last_num_q, last_num_d;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_dn, is_bad, step_dn;

  // Classify the incoming sample against the last accepted one (mod 2^WIDTH, so wrap is legal)
  always_comb begin
    delta   = num_in - last_num_q;
    is_up   = (delta == DELTA_UP);
    is_dn   = (delta == DELTA_DN);
    is_bad  = !(is_up || is_dn || (delta == '0));
    step_dn = is_dn;
  end

  // Next-state and registered-output logic; pulses default low so idle cycles clear them
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    run_d       = run_q;
    dir_d       = dir_q;
    locked_d    = locked_q;
    rev_d       = 1'b0;
    step_err_d  = 1'b0;
    err_count_d = err_count_q;
    last_num_d  = last_num_q;

    if (valid_in) begin
      last_num_d = num_in;
      case (state_q)
        S_EMPTY: begin
          run_d   = 4'd0;
          state_d = S_TRACK;
        end
        S_TRACK: begin
          if (is_bad) begin
            step_err_d  = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            run_d       = 4'd0;
          end else if (is_up || is_dn) begin
            if ((step_dn == cand_q) && (run_q != 4'd0)) begin
              run_d = (run_q >= LOCK_RUN) ? LOCK_RUN : run_q + 4'd1;
            end else begin
              cand_d = step_dn;
              run_d  = 4'd1;
            end
            if (run_d >= LOCK_RUN) begin
              state_d  = S_LOCKED;
              dir_d    = cand_d;
              locked_d = 1'b1;
            end
          end
        end
        S_LOCKED: begin
          if (is_bad) begin
            step_err_d  = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? err_count_q : err_count_q + 8'd1;
            run_d       = 4'd0;
            state_d     = S_TRACK;
            locked_d    = 1'b0;
          end else if ((is_up || is_dn) && (step_dn != dir_q)) begin
            // A clean opposite step is a legitimate mode change of the counter
            dir_d = ~dir_q;
            rev_d = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State register with asynchronous active-low clear discarding all history
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= S_EMPTY;
      cand_q      <= 1'b0;
      run_q       <= 4'd0;
      dir_q       <= 1'b0;
      locked_q    <= 1'b0;
      rev_q       <= 1'b0;
      step_err_q  <= 1'b0;
      err_count_q <= 8'd0;
      last_num_q  <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      run_q       <= run_d;
      dir_q       <= dir_d;
      locked_q    <= locked_d;
      rev_q       <= rev_d;
      step_err_q  <= step_err_d;
      err_count_q <= err_count_d;
      last_num_q  <= last_num_d;
    end
  end

  assign dir_out   = dir_q;
  assign locked    = locked_q;
  assign rev       = rev_q;
  assign step_err  = step_err_q;
  assign err_count = err_count_q;
  assign last_num  = last_num_q;

endmodule

// File: tb/tb_count_direction_decoder.sv
// tb/tb_count_direction_decoder.sv - scoreboard bench with behavioural direction model
module tb_count_direction_decoder;

  localparam int W      = 3;
  localparam int M      = 1 << W;
  localparam int LOCK_N = 2;

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] num_in = '0;
  logic         valid_in = 1'b0;
  logic         dir_out, locked, rev, step_err;
  logic [7:0]   err_count;
  logic [W-1:0] last_num;

  count_direction_decoder #(.WIDTH(W), .LOCK_N(LOCK_N)) dut (
    .clk(clk), .clear(clear), .num_in(num_in), .valid_in(valid_in),
    .dir_out(dir_out), .locked(locked), .rev(rev), .step_err(step_err),
    .err_count(err_count), .last_num(last_num)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dir;
    int lck;
    int rv;
    int se;
    int ec;
    int ln;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;

  // model: "seen" = a reference sample exists, "lk" = direction confirmed
  int m_seen, m_lk, m_dir, m_cand, m_run, m_err, m_last;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seen = 0; m_lk = 0; m_dir = 0; m_cand = 0; m_run = 0; m_err = 0; m_last = 0;
  endtask

  task automatic model_step(input int v, input int n, output exp_t e);
    int d, s, rv, se;
    rv = 0; se = 0;
    if (v != 0) begin
      if (m_seen == 0) begin
        m_seen = 1;
        m_run  = 0;
      end else begin
        d = (n - m_last + M) % M;
        if (d == 1 || d == M - 1) begin
          s = (d == M - 1) ? 1 : 0;
          if (m_lk != 0) begin
            if (s != m_dir) begin m_dir = s; rv = 1; end
          end else begin
            if (s == m_cand && m_run >= 1) m_run = (m_run + 1 > LOCK_N) ? LOCK_N : m_run + 1;
            else begin m_cand = s; m_run = 1; end
            if (m_run >= LOCK_N) begin m_lk = 1; m_dir = m_cand; end
          end
        end else if (d != 0) begin
          se = 1;
          m_err = (m_err < 255) ? m_err + 1 : 255;
          m_run = 0;
          m_lk = 0;
        end
      end
      m_last = n;
    end
    e.dir = m_dir; e.lck = m_lk; e.rv = rv; e.se = se; e.ec = m_err; e.ln = m_last;
  endtask

  task automatic drive(input int v, input int n);
    exp_t e;
    @(negedge clk);
    valid_in = v[0];
    num_in   = W'(n);
    model_step(v, n, e);
    exp_q.push_back(e);
  endtask

  task automatic samples(input int list[$]);
    foreach (list[i]) drive(1, list[i]);
  endtask

  task automatic hold_clear(input int cycles);
    @(negedge clk);
    valid_in = 1'b0;
    clear = 1'b0;
    exp_q.delete();
    model_reset();
    repeat (cycles) @(negedge clk);
    clear = 1'b1;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: pops one expectation per cycle after the edge that consumed the stimulus
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("dir_out", int'(dir_out), mon_e.dir);
      chk("locked", int'(locked), mon_e.lck);
      chk("rev", int'(rev), mon_e.rv);
      chk("step_err", int'(step_err), mon_e.se);
      chk("err_count", int'(err_count), mon_e.ec);
      chk("last_num", int'(last_num), mon_e.ln);
      if (rev && step_err) chk("rev_and_step_err", 1, 0);
    end
  end

  initial begin
    int cur, sdir, r, wait_cyc;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_locked", int'(locked), 0);
    chk("reset_err_count", int'(err_count), 0);
    chk("reset_last_num", int'(last_num), 0);
    clear = 1'b1;

    samples('{0, 1, 2, 3});
    settle();
    chk("t1_locked", int'(locked), 1);
    chk("t1_dir", int'(dir_out), 0);
    samples('{4, 5, 6, 7, 0, 1, 0, 7, 6, 5});
    settle();
    chk("t2_dir_down", int'(dir_out), 1);
    samples('{2});
    settle();
    chk("t3_err_count", int'(err_count), 1);
    chk("t3_locked", int'(locked), 0);
    samples('{1, 0});
    settle();
    chk("t3_relock", int'(locked), 1);
    chk("t3_relock_dir", int'(dir_out), 1);

    hold_clear(2);
    drive(1, 3); drive(0, 0); drive(1, 3); drive(1, 3); drive(0, 6);
    drive(1, 4); drive(0, 1); drive(1, 4); drive(1, 5); drive(0, 2);
    settle();
    chk("t4_locked", int'(locked), 1);
    chk("t4_last_num", int'(last_num), 5);

    hold_clear(1);
    for (int i = 0; i < 300; i++) drive(1, (i % 2) * 4);
    settle();
    chk("t5_err_sat", int'(err_count), 255);

    hold_clear(1);
    samples('{0, 1, 2});
    @(negedge clk);
    valid_in = 1'b0;
    #1;
    chk("t6_pre_locked", int'(locked), 1);
    #1;
    clear = 1'b0;
    exp_q.delete();
    model_reset();
    #1;
    chk("t6_async_locked", int'(locked), 0);
    chk("t6_async_dir", int'(dir_out), 0);
    chk("t6_async_last", int'(last_num), 0);
    chk("t6_async_err", int'(err_count), 0);
    chk("t6_async_pulses", int'(rev) + int'(step_err), 0);
    @(negedge clk);
    clear = 1'b1;
    samples('{2, 3});
    settle();
    chk("t6_not_yet", int'(locked), 0);
    samples('{4});
    settle();
    chk("t6_relock", int'(locked), 1);
    chk("t6_dir", int'(dir_out), 0);

    cur = 4; sdir = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) < 3) drive(0, $urandom_range(0, M - 1));
      else begin
        r = $urandom_range(0, 19);
        if (r < 1) sdir = 1 - sdir;
        if (r < 13) cur = (sdir != 0) ? (cur + M - 1) % M : (cur + 1) % M;
        else if (r < 15) cur = (sdir != 0) ? (cur + 1) % M : (cur + M - 1) % M;
        else if (r < 17) cur = cur;
        else cur = $urandom_range(0, M - 1);
        drive(1, cur);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
